// File: rtl/rib_xbar_pkg.sv
// Shared constants for the RIB crossbar: slave select field, default priority
// class, starvation limit and the slave index map.
package rib_xbar_pkg;

  localparam int SEL_BITS         = 4;
  localparam int NUM_MASTERS_DEF  = 6;
  localparam int NUM_SLAVES_DEF   = 6;
  localparam int STARVE_LIMIT_DEF = 15;
  localparam int CNT_W            = 4;

  localparam logic [NUM_MASTERS_DEF-1:0] HIPRI_MASK_DEF = 6'b100100;

  typedef enum logic [SEL_BITS-1:0] {
    SLV_ROM   = 4'd0,
    SLV_RAM   = 4'd1,
    SLV_TIMER = 4'd2,
    SLV_UART  = 4'd3,
    SLV_GPIO  = 4'd4,
    SLV_SPI   = 4'd5
  } slave_idx_e;

  // Single-step modulo for round-robin offsets, where idx < 2*n.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/rib_rr_arb.sv
// Per-slave round-robin arbiter with three priority classes:
// starved, high-priority, then everyone else.
module rib_rr_arb
  import rib_xbar_pkg::*;
#(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] hipri,
  input  logic [N-1:0] starved,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] idx;
  logic [N-1:0]  pool;

  always_comb begin
    if (|(req & starved))    pool = req & starved;
    else if (|(req & hipri)) pool = req & hipri;
    else                     pool = req;
  end

  // Scan from the farthest offset down so the candidate nearest ptr is written last.
  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'(rr_wrap(int'(ptr) + k, N));
      if (pool[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        ptr_nxt  = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       ptr <= '0;
    else if (|gnt) ptr <= ptr_nxt;
  end

endmodule

// File: rtl/rib_xbar.sv
// Multi-master, multi-slave RIB crossbar: address decode, per-slave arbitration,
// per-master starvation counters and single-cycle request/read-data muxing.
module rib_xbar
  import rib_xbar_pkg::*;
#(
  parameter int                     NUM_MASTERS  = NUM_MASTERS_DEF,
  parameter int                     NUM_SLAVES   = NUM_SLAVES_DEF,
  parameter int                     ADDR_W       = 32,
  parameter int                     DATA_W       = 32,
  parameter logic [NUM_MASTERS-1:0] HIPRI_MASK   = HIPRI_MASK_DEF,
  parameter int                     STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_MASTERS-1:0]        m_req_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_data_i,
  output logic [NUM_MASTERS*DATA_W-1:0] m_data_o,
  output logic [NUM_MASTERS-1:0]        m_hold_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [NUM_MASTERS-1:0]        m_starve_o,
  output logic [NUM_SLAVES-1:0]         s_req_o,
  output logic [NUM_SLAVES-1:0]         s_we_o,
  output logic [NUM_SLAVES*ADDR_W-1:0]  s_addr_o,
  output logic [NUM_SLAVES*DATA_W-1:0]  s_data_o,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_data_i
);

  logic [SEL_BITS-1:0]    sel     [NUM_MASTERS];
  logic [CNT_W-1:0]       cnt     [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] gnt     [NUM_SLAVES];
  logic [NUM_MASTERS-1:0] mapped;
  logic [NUM_MASTERS-1:0] act;
  logic [NUM_MASTERS-1:0] starved;
  logic [NUM_MASTERS-1:0] granted;

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_master
    assign sel[m]     = m_addr_i[m*ADDR_W + ADDR_W - 1 -: SEL_BITS];
    assign mapped[m]  = int'(sel[m]) < NUM_SLAVES;
    assign act[m]     = m_req_i[m] & mapped[m];
    assign starved[m] = (cnt[m] == CNT_W'(STARVE_LIMIT));

    // Held cycles accumulate until grant; any break in the request restarts the count.
    always_ff @(posedge clk) begin
      if (rst)                         cnt[m] <= '0;
      else if (act[m] && !granted[m]) begin
        if (!starved[m])               cnt[m] <= cnt[m] + 1'b1;
      end
      else                             cnt[m] <= '0;
    end
  end

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slave
    logic [NUM_MASTERS-1:0] cand;

    always_comb begin
      cand = '0;
      for (int m = 0; m < NUM_MASTERS; m++)
        cand[m] = act[m] && (sel[m] == SEL_BITS'(s));
    end

    rib_rr_arb #(.N(NUM_MASTERS)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (cand),
      .hipri   (HIPRI_MASK),
      .starved (starved),
      .gnt     (gnt[s])
    );
  end

  always_comb begin
    granted  = '0;
    m_data_o = '0;
    s_req_o  = '0;
    s_we_o   = '0;
    s_addr_o = '0;
    s_data_o = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (gnt[s][m]) begin
          granted[m]                    = 1'b1;
          s_req_o[s]                    = 1'b1;
          s_we_o[s]                     = m_we_i[m];
          s_addr_o[s*ADDR_W +: ADDR_W]  = m_addr_i[m*ADDR_W +: ADDR_W];
          s_data_o[s*DATA_W +: DATA_W]  = m_data_i[m*DATA_W +: DATA_W];
          m_data_o[m*DATA_W +: DATA_W]  = s_data_i[s*DATA_W +: DATA_W];
        end
      end
    end
    m_hold_o   = act & ~granted;
    m_err_o    = m_req_i & ~mapped;
    m_starve_o = starved;
    // An in-flight transfer is dropped outright while reset is held.
    if (rst) begin
      m_data_o   = '0;
      s_req_o    = '0;
      s_we_o     = '0;
      s_addr_o   = '0;
      s_data_o   = '0;
      m_hold_o   = '0;
      m_err_o    = '0;
      m_starve_o = '0;
    end
  end

endmodule

// File: tb/tb_rib_xbar.sv
// Self-checking bench for rib_xbar: directed scenarios followed by random traffic,
// all checked against a per-cycle reference model of the arbitration rules.
module tb_rib_xbar;

  localparam int NM = 6;
  localparam int NS = 6;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [NM-1:0] HIPRI = 6'b100100;
  localparam int LIMIT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_req_i, m_we_i;
  logic [NM*AW-1:0]  m_addr_i;
  logic [NM*DW-1:0]  m_data_i, m_data_o;
  logic [NM-1:0]     m_hold_o, m_err_o, m_starve_o;
  logic [NS-1:0]     s_req_o, s_we_o;
  logic [NS*AW-1:0]  s_addr_o;
  logic [NS*DW-1:0]  s_data_o, s_data_i;

  rib_xbar dut (
    .clk        (clk),
    .rst        (rst),
    .m_req_i    (m_req_i),
    .m_we_i     (m_we_i),
    .m_addr_i   (m_addr_i),
    .m_data_i   (m_data_i),
    .m_data_o   (m_data_o),
    .m_hold_o   (m_hold_o),
    .m_err_o    (m_err_o),
    .m_starve_o (m_starve_o),
    .s_req_o    (s_req_o),
    .s_we_o     (s_we_o),
    .s_addr_o   (s_addr_o),
    .s_data_o   (s_data_o),
    .s_data_i   (s_data_i)
  );

  always #5 clk = ~clk;

  // stimulus
  logic [NM-1:0] rq, we;
  logic [31:0]   ad [NM];
  logic [31:0]   dt [NM];
  logic [31:0]   sd [NS];

  // reference model state and expectations
  int mptr [NS];
  int mcnt [NM];
  int win  [NS];
  logic [NM-1:0]    e_hold, e_err, e_starve;
  logic [NS-1:0]    e_sreq, e_swe;
  logic [NS*AW-1:0] e_saddr;
  logic [NS*DW-1:0] e_sdata;
  logic [NM*DW-1:0] e_mdata;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < NM; i++) begin
      m_addr_i[i*AW +: AW] = ad[i];
      m_data_i[i*DW +: DW] = dt[i];
    end
    for (int s = 0; s < NS; s++) s_data_i[s*DW +: DW] = sd[s];
    m_req_i = rq;
    m_we_i  = we;
  endtask

  function automatic int slv_of(input int i);
    logic [31:0] a;
    a = ad[i];
    return int'(a[31:28]);
  endfunction

  function automatic bit in_class(input int cls, input int i);
    if (cls == 0) return mcnt[i] == LIMIT;
    if (cls == 1) return HIPRI[i];
    return 1'b1;
  endfunction

  task automatic model_eval();
    int i;
    e_hold = '0; e_err = '0; e_starve = '0; e_sreq = '0; e_swe = '0;
    e_saddr = '0; e_sdata = '0; e_mdata = '0;
    for (int s = 0; s < NS; s++) win[s] = -1;
    if (rst) return;
    for (int s = 0; s < NS; s++)
      for (int cls = 0; cls < 3; cls++)
        for (int k = 0; k < NM; k++) begin
          i = (mptr[s] + k) % NM;
          if (win[s] < 0 && rq[i] && slv_of(i) == s && in_class(cls, i)) win[s] = i;
        end
    for (int m = 0; m < NM; m++) begin
      e_starve[m] = (mcnt[m] == LIMIT);
      e_err[m]    = rq[m] && slv_of(m) >= NS;
      e_hold[m]   = rq[m] && slv_of(m) < NS;
    end
    for (int s = 0; s < NS; s++)
      if (win[s] >= 0) begin
        e_hold[win[s]]               = 1'b0;
        e_sreq[s]                    = 1'b1;
        e_swe[s]                     = we[win[s]];
        e_saddr[s*AW +: AW]          = ad[win[s]];
        e_sdata[s*DW +: DW]          = dt[win[s]];
        e_mdata[win[s]*DW +: DW]     = sd[s];
      end
  endtask

  task automatic model_update();
    if (rst) begin
      for (int s = 0; s < NS; s++) mptr[s] = 0;
      for (int m = 0; m < NM; m++) mcnt[m] = 0;
      return;
    end
    for (int s = 0; s < NS; s++)
      if (win[s] >= 0) mptr[s] = (win[s] + 1) % NM;
    for (int m = 0; m < NM; m++)
      mcnt[m] = e_hold[m] ? ((mcnt[m] < LIMIT) ? mcnt[m] + 1 : LIMIT) : 0;
  endtask

  task automatic check_all();
    chk("hold",   m_hold_o,   e_hold);
    chk("err",    m_err_o,    e_err);
    chk("starve", m_starve_o, e_starve);
    chk("s_req",  s_req_o,    e_sreq);
    chk("s_we",   s_we_o,     e_swe);
    chk("s_addr", s_addr_o,   e_saddr);
    chk("s_data", s_data_o,   e_sdata);
    chk("m_data", m_data_o,   e_mdata);
  endtask

  task automatic cyc_begin();
    drive();
    #3;
    model_eval();
    check_all();
  endtask

  task automatic cyc_end();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rq = '0; we = '0;
    cyc_begin();
    cyc_end();
  endtask

  task automatic set_m(input int i, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    rq[i] = r; we[i] = w; ad[i] = a; dt[i] = d;
  endtask

  logic [31:0] rnd;
  int          r;

  initial begin
    rst = 1'b1; rq = '0; we = '0;
    for (int i = 0; i < NM; i++) begin ad[i] = '0; dt[i] = '0; end
    for (int s = 0; s < NS; s++) sd[s] = 32'hA000_0000 | s;
    for (int s = 0; s < NS; s++) mptr[s] = 0;
    for (int m = 0; m < NM; m++) mcnt[m] = 0;
    @(posedge clk); #1;

    // reset with active requests: everything must stay quiet
    set_m(1, 1, 1, 32'h1000_0000, 32'h55);
    cyc_begin();
    chk("rst_sreq", s_req_o, '0);
    chk("rst_hold", m_hold_o, '0);
    cyc_end();
    rst = 1'b0;
    idle();

    // contention: M1 and M4 on rom alternate starting with M1
    set_m(1, 1, 0, 32'h0000_0010, 0);
    set_m(4, 1, 0, 32'h0000_0010, 0);
    for (int c = 0; c < 4; c++) begin
      cyc_begin();
      chk("contend_hold1", m_hold_o[1], (c % 2) == 1);
      chk("contend_hold4", m_hold_o[4], (c % 2) == 0);
      chk("contend_held_data", (c % 2 == 0) ? m_data_o[4*DW +: DW] : m_data_o[1*DW +: DW], '0);
      cyc_end();
    end
    idle();

    // parallel: M0 reads ram, M3 writes gpio in the same cycle
    set_m(0, 1, 0, 32'h1000_0004, 0);
    set_m(3, 1, 1, 32'h4000_0004, 32'h3);
    cyc_begin();
    chk("par_sreq", {s_req_o[4], s_req_o[1]}, 2'b11);
    chk("par_we4", s_we_o[4], 1'b1);
    chk("par_data4", s_data_o[4*DW +: DW], 32'h3);
    chk("par_rdata0", m_data_o[0 +: DW], 32'hA000_0001);
    cyc_end();
    idle();

    // priority: JTAG M2 beats M1 on rom
    set_m(2, 1, 0, 32'h0000_0000, 0);
    set_m(1, 1, 0, 32'h0000_0004, 0);
    cyc_begin();
    chk("prio_hold2", m_hold_o[2], 1'b0);
    chk("prio_hold1", m_hold_o[1], 1'b1);
    cyc_end();
    idle();

    // starvation: M5 (hipri) hogs rom while M4 waits
    set_m(5, 1, 0, 32'h0000_0008, 0);
    set_m(4, 1, 0, 32'h0000_0020, 0);
    for (int c = 0; c < LIMIT; c++) begin
      cyc_begin();
      chk("starve_wait_hold4", m_hold_o[4], 1'b1);
      chk("starve_wait_flag4", m_starve_o[4], 1'b0);
      cyc_end();
    end
    cyc_begin();
    chk("starve_flag4", m_starve_o[4], 1'b1);
    chk("starve_grant4", m_hold_o[4], 1'b0);
    chk("starve_hold5", m_hold_o[5], 1'b1);
    cyc_end();
    cyc_begin();
    chk("starve_clear4", m_starve_o[4], 1'b0);
    cyc_end();
    idle();

    // unmapped address
    set_m(0, 1, 0, 32'h7000_0000, 0);
    cyc_begin();
    chk("unmap_err0", m_err_o[0], 1'b1);
    chk("unmap_hold0", m_hold_o[0], 1'b0);
    chk("unmap_data0", m_data_o[0 +: DW], '0);
    chk("unmap_sreq", s_req_o, '0);
    cyc_end();
    idle();

    // reset mid-write; rom pointer is first moved away from 0
    set_m(1, 1, 0, 32'h0000_0000, 0);
    cyc_begin();
    cyc_end();
    rq = '0;
    set_m(0, 1, 1, 32'h1000_0010, 32'hDEAD_BEEF);
    rst = 1'b1;
    cyc_begin();
    chk("rstw_we1", s_we_o[1], 1'b0);
    chk("rstw_sreq", s_req_o, '0);
    cyc_end();
    rst = 1'b0;
    rq = '0;
    set_m(1, 1, 0, 32'h0000_0010, 0);
    set_m(4, 1, 0, 32'h0000_0010, 0);
    cyc_begin();
    chk("rstw_hold1", m_hold_o[1], 1'b0);
    chk("rstw_hold4", m_hold_o[4], 1'b1);
    cyc_end();
    idle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NM; i++) begin
        r   = $urandom_range(0, 9);
        rnd = $urandom;
        rq[i] = ($urandom_range(0, 3) != 0);
        we[i] = rnd[0];
        ad[i] = {(r < 8) ? 4'(r % 4) : 4'(6 + (r & 1)), rnd[27:0]};
        dt[i] = $urandom;
      end
      for (int s = 0; s < NS; s++) sd[s] = $urandom;
      cyc_begin();
      cyc_end();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rib_xbar.md
# rib_xbar

Parametrised multi-master, multi-slave RIB crossbar for the dual-core tinyriscv SoC. It replaces the single-arbiter rib. Each slave has its own arbiter, so different masters can reach different slaves in the same cycle. Each master gets its own hold flag, which feeds that core's `rib_hold_flag_i` or stalls its JTAG master. Arbitration is round-robin with a high-priority class for debug masters and starvation promotion, so a core's always-requesting fetch port cannot lock out the other core.

## Interface
- NUM_MASTERS, 6, master count (per core: ex, pc, jtag).
- NUM_SLAVES, 6, slave count (rom, ram, timer, uart, gpio, spi).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- SEL_BITS, 4, slave select field, taken as addr[ADDR_W-1 -: SEL_BITS].
- HIPRI_MASK, 6'b100100, masters in the high-priority class (both JTAG masters).
- STARVE_LIMIT, 15, consecutive held cycles before a master is promoted; counters are 4 bits wide.
- clk  in  1  clock.
- rst  in  1  reset: rst, synchronous, active-high; clock clk.
- m_req_i  in  NUM_MASTERS  per-master request.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_addr_i  in  NUM_MASTERS*ADDR_W  flattened addresses; master i is at [i*ADDR_W +: ADDR_W].
- m_data_i  in  NUM_MASTERS*DATA_W  flattened write data.
- m_data_o  out  NUM_MASTERS*DATA_W  read data returned to each master.
- m_hold_o  out  NUM_MASTERS  master is requesting but not granted this cycle.
- m_err_o  out  NUM_MASTERS  request targets an unmapped slave index.
- m_starve_o  out  NUM_MASTERS  starvation counter has reached STARVE_LIMIT.
- s_req_o  out  NUM_SLAVES  slave is accessed this cycle.
- s_we_o  out  NUM_SLAVES  slave write enable.
- s_addr_o  out  NUM_SLAVES*ADDR_W  slave address; the full address is passed through.
- s_data_o  out  NUM_SLAVES*DATA_W  slave write data.
- s_data_i  in  NUM_SLAVES*DATA_W  slave read data, combinational from the slave.

## Operation
- **Decode.** sel_i = m_addr_i[i] select field.
  - If sel_i >= NUM_SLAVES: the request is unmapped. The master is never held, m_err_o[i]=1, m_data_o[i]=0, and no slave is touched.
- **Candidate set.** For slave s, candidates are the masters with m_req_i=1 and a mapped sel_i==s.
- **Priority, highest first.**
  1. Starved candidates (counter == STARVE_LIMIT).
  2. HIPRI_MASK candidates.
  3. All other candidates.
- **Within a class.** Round-robin search starting at ptr[s], upward, wrapping modulo NUM_MASTERS. The first candidate found wins.
- **Granted master g on slave s.**
  - s_req_o[s]=1; s_we_o, s_addr_o and s_data_o carry master g's values.
  - m_data_o[g] = s_data_i[s].
  - m_hold_o[g]=0.
- **Non-granted candidates.** m_hold_o=1, m_data_o=0.
- **Idle master** (m_req_i=0). hold=0, err=0, data_o=0.
- **Unselected slave.** req, we, addr and data outputs are all 0.
- **Pointer update.** ptr[s] (width $clog2(NUM_MASTERS), reset 0) becomes (g+1) mod NUM_MASTERS on any grant at slave s. It is unchanged when slave s is idle.
- **Starvation counter (per master, reset 0).**
  - Increments while requesting and held; saturates at STARVE_LIMIT.
  - Clears on grant, on an unmapped request, or when not requesting.
  - m_starve_o[i] = (counter == STARVE_LIMIT).
- **Simultaneous events.**
  - Several starved masters on one slave: resolved by round-robin order among them.
  - Masters targeting different slaves: all are granted in the same cycle.

## Timing
- Decode, arbitration, slave drive and read-data return are combinational, all within one cycle. This matches the single-cycle rom, ram and peripherals.
- Pointers and counters update on posedge clk from the current cycle's grants.
- A held master re-presents the same request; it is served no later than NUM_MASTERS-1 competing grants later under round-robin.
- The starvation bound applies when the master is outranked by a higher class: it is promoted on the cycle after STARVE_LIMIT held cycles.
- **While rst=1:**
  - All outputs are forced to 0 combinationally: s_req_o, s_we_o, m_hold_o, m_err_o, m_starve_o, m_data_o.
  - On the next edge, pointers and counters are 0.
- **Reset asserted mid-access:** the transaction is dropped. No write reaches a slave during any rst=1 cycle.

## Structure
- Put SEL_BITS, the default HIPRI_MASK and the slave index constants (ROM=0 … SPI=5) in core/defines.v alongside the existing MemAddrBus and MemBus definitions.
- Sub-module rib_rr_arb, one per slave, parametrised by N:
  - Inputs: req vector, hipri vector, starved vector.
  - Output: one-hot grant.
  - Holds its own pointer register.
- The top level does decode, the starvation counters, and muxing.

## Test plan
- **Contention.** M1 and M4 both fetch from 0x0000_0010 (rom) every cycle, HIPRI_MASK=0. Grants must alternate 1,4,1,4. The held master sees m_hold_o=1 and m_data_o=0.
- **Parallel access.** M0 reads ram 0x1000_0004 while M3 writes gpio 0x4000_0004 = 0x3. Both are granted in the same cycle; s_we_o[4]=1 and s_data_o[4]=0x3.
- **Priority.** M2 (JTAG) and M1 both request rom. M2 wins immediately and M1 is held.
- **Starvation promotion.** With default HIPRI_MASK, M5 keeps rom busy continuously while M4 requests rom for 15 cycles. m_starve_o[4] rises after the 15th held cycle. M4 is granted on the next cycle, and its counter returns to 0.
- **Unmapped address.** M0 reads 0x7000_0000. m_err_o[0]=1, m_hold_o[0]=0, m_data_o[0]=0, and all s_req_o=0.
- **Reset mid-write.** Assert rst during an M0 ram write. s_we_o[1]=0 that cycle. After release, all pointers are 0, so the first contention is won by the lowest-index candidate.
